div11_rr_sched: RTL and testbench



---
 rtl/div11_pkg.sv | 13 +
 rtl/div11_rr_sched_rr_arb.sv | 34 +++
 rtl/div_64_11.sv | 27 ++
 rtl/div11_rr_sched.sv | 68 ++++++
 tb/tb_div11_rr_sched.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/div11_pkg.sv
// div11_pkg: shared widths and the output-stage payload type for the divide-by-11 scheduler.
package div11_pkg;
  localparam int DIV11_X_W = 64;
  localparam int DIV11_Q_W = 61;
  localparam int DIV11_R_W = 4;
  localparam int DIV11_DIVISOR = 11;
  localparam int DIV11_ID_MAX_W = 4;
  typedef struct packed {
    logic [DIV11_ID_MAX_W-1:0] id;
    logic [DIV11_Q_W-1:0] q;
    logic [DIV11_R_W-1:0] r;
  } s2_pay_t;
endpackage

// File: rtl/div11_rr_sched_rr_arb.sv
// rr_arb: rotating-priority grant starting at ptr, ptr moves past each fired grant.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            fire
);
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;
  logic            found;
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NREQ);
      if (!found && valid[cand]) begin
        found = 1'b1;
        gnt_id = cand;
      end
    end
    fire = found & en;
    gnt = fire ? NREQ'(1) << gnt_id : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (fire) ptr <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
endmodule

// File: rtl/div_64_11.sv
// div_64_11: combinational 64-bit divide-by-11 core (restoring long division, 4-bit remainder).
module div_64_11 (
  input  logic [64:1] x,
  output logic [61:1] q,
  output logic [4:1]  r
);
  logic [4:0] t;
  logic [4:0] d;
  always_comb begin
    q = '0;
    r = '0;
    t = '0;
    d = '0;
    // the top three dividend bits can never reach 11, so they only seed the remainder
    for (int i = 64; i >= 62; i--) begin
      t = {r, x[i]};
      d = t - 5'd11;
      r = (t >= 5'd11) ? d[3:0] : t[3:0];
    end
    for (int i = 61; i >= 1; i--) begin
      t = {r, x[i]};
      d = t - 5'd11;
      q[i] = t >= 5'd11;
      r = (t >= 5'd11) ? d[3:0] : t[3:0];
    end
  end
endmodule

// File: rtl/div11_rr_sched.sv
// div11_rr_sched: round-robin shared divide-by-11 with registered input and output stages.
// Optional DIV11_SELFCHECK_EN adds chk_err, flagging results where q*11+r != x or r > 10.
module div11_rr_sched
  import div11_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_x,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [DIV11_Q_W-1:0] resp_q,
  output logic [DIV11_R_W-1:0] resp_r,
`ifdef DIV11_SELFCHECK_EN
  output logic                 chk_err,
`endif
  output logic                 busy
);
  logic                 s1_v, s2_v, s2_fire, s1_adv, s1_accept, fire;
  logic [DIV11_X_W-1:0] x_r;
  logic [ID_W-1:0]      id_r, gnt_id;
  logic [DIV11_Q_W-1:0] q;
  logic [DIV11_R_W-1:0] r;
  s2_pay_t              pay;
  assign s2_fire = s2_v & resp_ready;
  assign s1_adv = s1_v & (!s2_v | s2_fire);
  assign s1_accept = !s1_v | s1_adv;
  rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .clk(clk), .rst_n(rst_n), .valid(req_valid), .en(s1_accept),
    .gnt(req_ready), .gnt_id(gnt_id), .fire(fire)
  );
  div_64_11 u_div (.x(x_r), .q(q), .r(r));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v <= 1'b0;
      x_r <= '0;
      id_r <= '0;
    end else if (fire) begin
      s1_v <= 1'b1;
      x_r <= req_x[DIV11_X_W*gnt_id +: DIV11_X_W];
      id_r <= gnt_id;
    end else if (s1_adv) s1_v <= 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s2_v <= 1'b0;
      pay <= '0;
    end else if (s1_adv) begin
      s2_v <= 1'b1;
      pay <= '{id: DIV11_ID_MAX_W'(id_r), q: q, r: r};
    end else if (s2_fire) s2_v <= 1'b0;
`ifdef DIV11_SELFCHECK_EN
  logic [DIV11_X_W:0] prod;
  assign prod = ({4'b0, q} << 3) + ({4'b0, q} << 1) + {4'b0, q} + 65'(r);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chk_err <= 1'b0;
    else if (s1_adv) chk_err <= (prod != {1'b0, x_r}) || (r > 4'(DIV11_DIVISOR - 1));
`endif
  assign resp_valid = s2_v;
  assign resp_id = ID_W'(pay.id);
  assign resp_q = pay.q;
  assign resp_r = pay.r;
  assign busy = s1_v | s2_v;
endmodule

// File: tb/tb_div11_rr_sched.sv
// tb_div11_rr_sched: scoreboard bench; fires push expected results, a monitor pops on each response.
module tb_div11_rr_sched;
  typedef struct packed {
    logic [1:0]  id;
    logic [60:0] q;
    logic [3:0]  r;
    logic        c;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [255:0] req_x;
  logic         resp_valid, resp_ready;
  logic [1:0]   resp_id;
  logic [60:0]  resp_q;
  logic [3:0]   resp_r;
  logic         busy;
`ifdef DIV11_SELFCHECK_EN
  logic         chk_err;
`endif
  int checks = 0, failures = 0;
  exp_t sb[$];
  int fires[$];
  exp_t e_mon;
  logic [60:0] eq[4];
  logic [3:0]  er[4];
  int vp[4];
  logic [3:0]  last_f, last_rdy;
  logic auto_mode = 1'b0, rnd_mode = 1'b0, forcing = 1'b0;
  logic [63:0] tx[10] = '{64'd1000, 64'd0, 64'd10, 64'd11, 64'hFFFF_FFFF_FFFF_FFFF,
                          64'd121, 64'd12345, 64'h8000_0000_0000_0000, 64'd999999, 64'd22};
  logic [60:0] tq[10] = '{61'd90, 61'd0, 61'd0, 61'd1, 61'd1676976733973595601,
                          61'd11, 61'd1122, 61'd838488366986797800, 61'd90909, 61'd2};
  logic [3:0]  tr[10] = '{4'd10, 4'd0, 4'd10, 4'd0, 4'd4, 4'd0, 4'd3, 4'd8, 4'd0, 4'd0};
  logic [60:0] snap_q;
  logic [3:0]  snap_r;
  logic [1:0]  snap_id;
  int nf;

  always #5 clk = ~clk;

  div11_rr_sched #(.NREQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_q(resp_q),
    .resp_r(resp_r),
`ifdef DIV11_SELFCHECK_EN
    .chk_err(chk_err),
`endif
    .busy(busy)
  );

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic load(int i, logic [63:0] x, logic [60:0] q, logic [3:0] r);
    req_x[64*i +: 64] = x;
    eq[i] = q;
    er[i] = r;
  endtask

  task automatic next(int i);
    logic [63:0] x;
    if (rnd_mode) begin
      x = {$urandom, $urandom};
      load(i, x, 61'(x / 64'd11), 4'(x % 64'd11));
    end else begin
      vp[i] = (vp[i] + 1) % 10;
      load(i, tx[vp[i]], tq[vp[i]], tr[vp[i]]);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_rdy = req_ready;
    last_f = req_valid & req_ready;
    chk("rdy_onehot0", 64'($onehot0(req_ready)), 1);
    for (int i = 0; i < 4; i++)
      if (last_f[i]) begin
        e.id = 2'(i);
        e.q = eq[i];
        e.r = forcing ? 4'd11 : er[i];
        e.c = forcing;
        sb.push_back(e);
        fires.push_back(i);
      end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (last_f[i]) begin
        if (auto_mode) next(i);
        else req_valid[i] = 1'b0;
      end
  endtask

  task automatic single(int k);
    load(0, tx[k], tq[k], tr[k]);
    req_valid = 4'b0001;
    last_f = '0;
    for (int c = 0; c < 10 && !last_f[0]; c++) cycle();
    chk("single_fire", 64'(last_f[0]), 1);
    req_valid = '0;
    @(negedge clk);
    chk("single_lat1", 64'(resp_valid), 0);
    @(negedge clk);
    chk("single_lat2", 64'(resp_valid), 1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (rst_n && resp_valid && resp_ready) begin
      chk("resp_expected", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e_mon = sb.pop_front();
        chk("resp_id", 64'(resp_id), 64'(e_mon.id));
        chk("resp_q", 64'(resp_q), 64'(e_mon.q));
        chk("resp_r", 64'(resp_r), 64'(e_mon.r));
`ifdef DIV11_SELFCHECK_EN
        chk("chk_err", 64'(chk_err), 64'(e_mon.c));
`endif
      end
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_x = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_resp_q", 64'(resp_q), 0);
    chk("rst_resp_r", 64'(resp_r), 0);
    chk("rst_resp_id", 64'(resp_id), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) single(k);
    // round robin, all requesters valid; ptr sits at 1 after five grants to requester 0
    auto_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vp[i] = i;
      load(i, tx[i], tq[i], tr[i]);
    end
    fires.delete();
    req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      cycle();
      chk("rr_one_fire", 64'($countones(last_f)), 1);
    end
    chk("rr_first", 64'(fires[0]), 1);
    for (int k = 1; k < fires.size(); k++)
      chk("rr_order", 64'(fires[k]), 64'((fires[k-1] + 1) % 4));
    req_valid = '0;
    repeat (4) cycle();
    // stall from empty: two accepts fill both stages, then nothing more
    resp_ready = 1'b0;
    req_valid = 4'hF;
    nf = 0;
    for (int s = 1; s <= 5; s++) begin
      cycle();
      nf += $countones(last_f);
      if (s >= 3) chk("stall_rdy", 64'(last_rdy), 0);
      if (s == 3) begin
        snap_q = resp_q;
        snap_r = resp_r;
        snap_id = resp_id;
      end
      if (s > 3) begin
        chk("stall_valid", 64'(resp_valid), 1);
        chk("stall_q", 64'(resp_q), 64'(snap_q));
        chk("stall_r", 64'(resp_r), 64'(snap_r));
        chk("stall_id", 64'(resp_id), 64'(snap_id));
      end
    end
    chk("stall_accepted", 64'(nf), 2);
    resp_ready = 1'b1;
    repeat (6) cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("stall_drained", 64'(sb.size()), 0);
    // reset with both stages full
    resp_ready = 1'b0;
    req_valid = 4'hF;
    repeat (3) cycle();
    chk("full_busy", 64'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 64'(resp_valid), 0);
    chk("midrst_busy", 64'(busy), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    cycle();
    chk("rst_first_grant", 64'(last_f), 64'(4'b0001));
    req_valid = '0;
    repeat (4) cycle();
`ifdef DIV11_SELFCHECK_EN
    rnd_mode = 1'b1;
    for (int i = 0; i < 4; i++) next(i);
    req_valid = 4'hF;
    repeat (10000) cycle();
    req_valid = '0;
    repeat (4) cycle();
    rnd_mode = 1'b0;
    auto_mode = 1'b0;
    forcing = 1'b1;
    force dut.u_div.r = 4'd11;
    single(6);
    release dut.u_div.r;
    forcing = 1'b0;
    repeat (2) cycle();
`endif
    chk("final_drained", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
